spi_frame_receiver: RTL

//  Front-end SPI slave stage (mode 0, MSB first) that sits directly upstream of the
//  SPI register file. It synchronises the asynchronous sclk/copi/ncs pins into clk,

---
 rtl/spi_pkg.sv | 38 +++
 rtl/sync_edge_detect.sv | 32 +++
 rtl/spi_frame_receiver.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared constants for the SPI front end and the register file behind it.
package spi_pkg;

    localparam int unsigned FRAME_BITS = 16;

    // Field positions inside a frame
    localparam int unsigned RW_BIT     = 15;
    localparam int unsigned ADDR_MSB   = 14;
    localparam int unsigned ADDR_LSB   = 8;
    localparam int unsigned DATA_MSB   = 7;
    localparam int unsigned DATA_LSB   = 0;

    localparam int unsigned ADDR_W     = ADDR_MSB - ADDR_LSB + 1;
    localparam int unsigned DATA_W     = DATA_MSB - DATA_LSB + 1;

    // Receiver FSM encoding
    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    // Assemble a frame word from its fields
    function automatic logic [FRAME_BITS-1:0] pack_frame(
        input logic              rw,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        logic [FRAME_BITS-1:0] f;
        f                    = '0;
        f[RW_BIT]            = rw;
        f[ADDR_MSB:ADDR_LSB] = addr;
        f[DATA_MSB:DATA_LSB] = data;
        return f;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop pin synchroniser with rise/fall detection against a 1-cycle delay.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pin,
    output logic o_sync,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Synchroniser chain plus delayed copy of the synchronised level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync   = r_sync[SYNC_STAGES-1];
    assign o_rise_c = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall_c = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_frame_receiver.sv
// SPI mode-0 slave front end: synchronises pins, deserialises one frame per ncs window,
// and emits the parallel word with a valid strobe or an error strobe.
module spi_frame_receiver #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FRAME_BITS  = spi_pkg::FRAME_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  copi,
    input  logic                  ncs,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_valid,
    output logic                  frame_err,
    output logic                  busy
);

    import spi_pkg::*;

    localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] ARM_WAIT = CNT_W'(SYNC_STAGES);

    logic w_ncs_s;
    logic w_ncs_rise;
    logic w_ncs_fall;
    logic w_sclk_level_unused;
    logic w_sclk_rise;
    logic w_sclk_fall_unused;
    logic w_copi_s;
    logic w_copi_rise_unused;
    logic w_copi_fall_unused;

    state_t                r_state;
    logic [CNT_W-1:0]      r_count;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  r_ovr;
    logic [FRAME_BITS-1:0] r_data;
    logic                  r_valid;
    logic                  r_err;
    logic                  r_busy;

    state_t                w_state_nxt;
    logic [CNT_W-1:0]      w_count_nxt;
    logic [FRAME_BITS-1:0] w_shift_nxt;
    logic                  w_ovr_nxt;
    logic [FRAME_BITS-1:0] w_data_nxt;
    logic                  w_valid_nxt;
    logic                  w_err_nxt;
    logic                  w_busy_nxt;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ncs_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_pin    (ncs),
        .o_sync   (w_ncs_s),
        .o_rise_c (w_ncs_rise),
        .o_fall_c (w_ncs_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_pin    (sclk),
        .o_sync   (w_sclk_level_unused),
        .o_rise_c (w_sclk_rise),
        .o_fall_c (w_sclk_fall_unused)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_copi_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_pin    (copi),
        .o_sync   (w_copi_s),
        .o_rise_c (w_copi_rise_unused),
        .o_fall_c (w_copi_fall_unused)
    );

    // State, datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ARM;
            r_count <= '0;
            r_shift <= '0;
            r_ovr   <= 1'b0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_shift <= w_shift_nxt;
            r_ovr   <= w_ovr_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_shift_nxt = r_shift;
        w_ovr_nxt   = r_ovr;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;

        case (r_state)
            // Let the synchronisers flush their reset value before trusting ncs_s high
            ST_ARM: begin
                if (r_count != ARM_WAIT) begin
                    w_count_nxt = r_count + CNT_W'(1);
                end else if (w_ncs_s) begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end
            end
            ST_IDLE: begin
                if (w_ncs_fall) begin
                    w_state_nxt = ST_SHIFT;
                    w_count_nxt = '0;
                    w_shift_nxt = '0;
                    w_ovr_nxt   = 1'b0;
                end
            end
            ST_SHIFT, ST_HOLD: begin
                if (w_ncs_rise) begin
                    w_state_nxt = ST_IDLE;
                    if (r_count == CNT_FULL && !r_ovr) begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else if (w_sclk_rise) begin
                    if (r_state == ST_SHIFT) begin
                        w_shift_nxt = {r_shift[FRAME_BITS-2:0], w_copi_s};
                        w_count_nxt = r_count + CNT_W'(1);
                        if (r_count == CNT_LAST) begin
                            w_state_nxt = ST_HOLD;
                        end
                    end else begin
                        w_ovr_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_ARM;
                w_count_nxt = '0;
            end
        endcase

        w_busy_nxt = (w_state_nxt == ST_SHIFT) || (w_state_nxt == ST_HOLD);
    end

    assign frame_data  = r_data;
    assign frame_valid = r_valid;
    assign frame_err   = r_err;
    assign busy        = r_busy;

endmodule
